morra_cinese_n: RTL and testbench

Parametrised rock-paper-scissors (morra cinese) match controller: the successor to the fixed four-bit game FSM, with configurable round limits, win margin and optional no-repeat rule, plus live score and round-count outputs. Sits between two player input ports and the scoreboard/display logic, and adjudicates one round per clock. All outputs are registered.

---
 rtl/morra_cinese_n.sv | 129 ++++++++++++
 tb/tb_morra_cinese_n.sv | 106 ++++++++++
 2 files changed

// File: rtl/morra_cinese_n.sv
// rtl/morra_cinese_n.sv - parametrised rock-paper-scissors match controller
// One round adjudicated per clock; scores, round count and results are registered.
module morra_cinese_n #(
  parameter int ROUND_W     = 2,
  parameter int MIN_ROUNDS  = 4,
  parameter int LEAD_TO_WIN = 2,
  parameter int NO_REPEAT   = 1,
  localparam int CW = $clog2(MIN_ROUNDS + 2**ROUND_W) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INIZIO,
  input  logic [ROUND_W-1:0] NUM_MANCHE,
  input  logic [1:0]         PRIMO,
  input  logic [1:0]         SECONDO,
  output logic [1:0]         MANCHE,
  output logic [1:0]         PARTITA,
  output logic [CW-1:0]      PUNTI_PRIMO,
  output logic [CW-1:0]      PUNTI_SECONDO,
  output logic [CW-1:0]      N_MANCHE
);

  typedef enum logic [1:0] {IDLE, GIOCO, FINE} state_t;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] SASSO = 2'b01;
  localparam logic [1:0] CARTA = 2'b10;
  localparam logic [1:0] FORB  = 2'b11;

  localparam logic signed [CW:0] LEAD_S   = (CW+1)'(LEAD_TO_WIN);
  localparam logic [CW-1:0]      MIN_R    = CW'(MIN_ROUNDS);

  state_t          state_q;
  logic [1:0]      manche_q, partita_q;
  logic [CW-1:0]   p1_q, p2_q, n_q, limit_q;
  logic [1:0]      mem_win_q, mem_move_q;

  logic [1:0]      res_d, leader_d, mem_move_d;
  logic [CW-1:0]   p1_d, p2_d, n_d, limit_d;
  logic            moves_ok, blocked, p1_beats, lead_ok, end_d;
  logic signed [CW:0] diff;

  assign limit_d = MIN_R + {{(CW-ROUND_W){1'b0}}, NUM_MANCHE};

  always_comb begin
    res_d      = NONE;
    blocked    = 1'b0;
    moves_ok   = (PRIMO != NONE) && (SECONDO != NONE);
    p1_beats   = (PRIMO == SASSO && SECONDO == FORB) ||
                 (PRIMO == FORB  && SECONDO == CARTA) ||
                 (PRIMO == CARTA && SECONDO == SASSO);
    // The last decisive winner may not replay the move it just won with.
    if (NO_REPEAT != 0)
      blocked = (mem_win_q == 2'b01 && PRIMO   == mem_move_q) ||
                (mem_win_q == 2'b10 && SECONDO == mem_move_q);
    if (moves_ok && !blocked) begin
      if (PRIMO == SECONDO) res_d = 2'b11;
      else if (p1_beats)    res_d = 2'b01;
      else                  res_d = 2'b10;
    end
    mem_move_d = (res_d == 2'b01) ? PRIMO : SECONDO;

    p1_d = p1_q + {{(CW-1){1'b0}}, res_d == 2'b01};
    p2_d = p2_q + {{(CW-1){1'b0}}, res_d == 2'b10};
    n_d  = n_q + {{(CW-1){1'b0}}, 1'b1};

    diff    = {1'b0, p1_d} - {1'b0, p2_d};
    lead_ok = (diff >= LEAD_S) || (-diff >= LEAD_S);
    end_d   = (lead_ok && (n_d >= MIN_R)) || (n_d == limit_q);

    if (p1_d > p2_d)      leader_d = 2'b01;
    else if (p2_d > p1_d) leader_d = 2'b10;
    else                  leader_d = 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      manche_q   <= NONE;
      partita_q  <= NONE;
      p1_q       <= '0;
      p2_q       <= '0;
      n_q        <= '0;
      limit_q    <= '0;
      mem_win_q  <= NONE;
      mem_move_q <= NONE;
    end else if (INIZIO) begin
      state_q    <= GIOCO;
      limit_q    <= limit_d;
      manche_q   <= NONE;
      partita_q  <= NONE;
      p1_q       <= '0;
      p2_q       <= '0;
      n_q        <= '0;
      mem_win_q  <= NONE;
      mem_move_q <= NONE;
    end else begin
      case (state_q)
        GIOCO: begin
          manche_q <= res_d;
          if (res_d != NONE) begin
            p1_q <= p1_d;
            p2_q <= p2_d;
            n_q  <= n_d;
            if (res_d == 2'b11) begin
              mem_win_q  <= NONE;
              mem_move_q <= NONE;
            end else begin
              mem_win_q  <= res_d;
              mem_move_q <= mem_move_d;
            end
            if (end_d) begin
              state_q   <= FINE;
              partita_q <= leader_d;
            end
          end
        end
        default: manche_q <= NONE;
      endcase
    end
  end

  assign MANCHE        = manche_q;
  assign PARTITA       = partita_q;
  assign PUNTI_PRIMO   = p1_q;
  assign PUNTI_SECONDO = p2_q;
  assign N_MANCHE      = n_q;

endmodule

// File: tb/tb_morra_cinese_n.sv
// tb/tb_morra_cinese_n.sv - directed-vector bench for morra_cinese_n
module tb_morra_cinese_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       INIZIO = 1'b0;
  logic [1:0] NUM_MANCHE = 2'b00;
  logic [1:0] PRIMO = 2'b00, SECONDO = 2'b00;
  logic [1:0] MANCHE, PARTITA;
  logic [3:0] PUNTI_PRIMO, PUNTI_SECONDO, N_MANCHE;

  int n_vec = 0;
  int n_bad = 0;

  morra_cinese_n dut (
    .clk(clk), .rst_n(rst_n), .INIZIO(INIZIO), .NUM_MANCHE(NUM_MANCHE),
    .PRIMO(PRIMO), .SECONDO(SECONDO), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .PUNTI_PRIMO(PUNTI_PRIMO), .PUNTI_SECONDO(PUNTI_SECONDO), .N_MANCHE(N_MANCHE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [1:0] em, input logic [1:0] ep,
                            input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] en);
    check({tag, ".manche"}, {6'd0, MANCHE}, {6'd0, em});
    check({tag, ".partita"}, {6'd0, PARTITA}, {6'd0, ep});
    check({tag, ".p1"}, {4'd0, PUNTI_PRIMO}, {4'd0, e1});
    check({tag, ".p2"}, {4'd0, PUNTI_SECONDO}, {4'd0, e2});
    check({tag, ".n"}, {4'd0, N_MANCHE}, {4'd0, en});
  endtask

  task automatic play(input string tag, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] em, input logic [1:0] ep,
                      input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] en);
    @(negedge clk);
    INIZIO = 1'b0; PRIMO = a; SECONDO = b;
    @(posedge clk); #1;
    expect_all(tag, em, ep, e1, e2, en);
  endtask

  task automatic start(input string tag, input logic [1:0] nm);
    @(negedge clk);
    INIZIO = 1'b1; NUM_MANCHE = nm; PRIMO = 2'b01; SECONDO = 2'b11;
    @(posedge clk); #1;
    expect_all(tag, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    #2;
    expect_all("rst_async", 2'b00, 2'b00, 4'd0, 4'd0, 4'd0);
    @(negedge clk); rst_n = 1'b1;

    play("idle_moves", 2'b01, 2'b11, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0);
    play("idle_moves2", 2'b10, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0);

    start("start_a", 2'd0);
    play("a_r1", 2'b01, 2'b11, 2'b01, 2'b00, 4'd1, 4'd0, 4'd1);
    play("a_r2", 2'b10, 2'b01, 2'b01, 2'b00, 4'd2, 4'd0, 4'd2);
    play("a_r3", 2'b11, 2'b10, 2'b01, 2'b00, 4'd3, 4'd0, 4'd3);
    play("a_r4", 2'b01, 2'b01, 2'b11, 2'b01, 4'd3, 4'd0, 4'd4);
    play("fine_moves", 2'b01, 2'b11, 2'b00, 2'b01, 4'd3, 4'd0, 4'd4);
    play("fine_hold", 2'b00, 2'b00, 2'b00, 2'b01, 4'd3, 4'd0, 4'd4);

    start("start_b", 2'd0);
    play("b_r1", 2'b01, 2'b11, 2'b01, 2'b00, 4'd1, 4'd0, 4'd1);
    play("b_repeat", 2'b01, 2'b10, 2'b00, 2'b00, 4'd1, 4'd0, 4'd1);
    play("b_r2", 2'b10, 2'b01, 2'b01, 2'b00, 4'd2, 4'd0, 4'd2);
    play("b_none", 2'b00, 2'b10, 2'b00, 2'b00, 4'd2, 4'd0, 4'd2);
    start("restart_mid", 2'd1);

    start("start_c", 2'd0);
    play("c_r1", 2'b10, 2'b10, 2'b11, 2'b00, 4'd0, 4'd0, 4'd1);
    play("c_r2", 2'b10, 2'b10, 2'b11, 2'b00, 4'd0, 4'd0, 4'd2);
    play("c_r3", 2'b10, 2'b10, 2'b11, 2'b00, 4'd0, 4'd0, 4'd3);
    play("c_r4", 2'b10, 2'b10, 2'b11, 2'b11, 4'd0, 4'd0, 4'd4);

    start("start_d", 2'd3);
    play("d_r1", 2'b01, 2'b11, 2'b01, 2'b00, 4'd1, 4'd0, 4'd1);
    play("d_r2", 2'b11, 2'b01, 2'b10, 2'b00, 4'd1, 4'd1, 4'd2);
    play("d_r3", 2'b01, 2'b11, 2'b01, 2'b00, 4'd2, 4'd1, 4'd3);
    play("d_r4", 2'b11, 2'b01, 2'b10, 2'b00, 4'd2, 4'd2, 4'd4);
    play("d_r5", 2'b01, 2'b11, 2'b01, 2'b00, 4'd3, 4'd2, 4'd5);
    play("d_r6", 2'b11, 2'b01, 2'b10, 2'b00, 4'd3, 4'd3, 4'd6);
    play("d_r7", 2'b01, 2'b11, 2'b01, 2'b01, 4'd4, 4'd3, 4'd7);

    start("start_e", 2'd0);
    play("e_r1", 2'b01, 2'b11, 2'b01, 2'b00, 4'd1, 4'd0, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    expect_all("rst_mid", 2'b00, 2'b00, 4'd0, 4'd0, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    play("post_rst", 2'b01, 2'b11, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
